// File: rtl/iob_parking_sensor.sv
// Parking-spot sensor front end: per-bit synchroniser and debouncer, occupancy,
// entry/exit counters and a maskable change interrupt behind an IOb native bus.
module iob_parking_sensor #(
  parameter int N_SENSORS    = 32,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_RST = 16,
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  input  logic [N_SENSORS-1:0]  sensor_in,
  output logic [N_SENSORS-1:0]  sensor_db,
  output logic                  irq
);

  localparam int PC_W = $clog2(N_SENSORS + 1);

  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_OCCUPIED = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CHANGED  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_MASK     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_DEBOUNCE = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_ENTRIES  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_EXITS    = ADDR_W'(6);

  function automatic logic [PC_W-1:0] popcount(input logic [N_SENSORS-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_SENSORS; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [PC_W-1:0]   b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + (DATA_W+1)'(b);
    return sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  endfunction

  logic [N_SENSORS-1:0] sync1, s, db, db_next, rise, fall;
  logic [N_SENSORS-1:0] changed, mask, w1c;
  logic [CNT_W-1:0]     cnt      [N_SENSORS];
  logic [CNT_W-1:0]     cnt_next [N_SENSORS];
  logic [CNT_W-1:0]     dbnc;
  logic [DATA_W-1:0]    entries, exits, rd_val;
  logic [PC_W-1:0]      pop_rise, pop_fall;
  logic                 wr;

  // A disagreeing sample advances the count; the (D+1)th consecutive one flips db.
  always_comb begin
    for (int i = 0; i < N_SENSORS; i++) begin
      db_next[i]  = db[i];
      cnt_next[i] = cnt[i] + CNT_W'(1);
      if (s[i] == db[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == dbnc) begin
        db_next[i]  = s[i];
        cnt_next[i] = '0;
      end
    end
  end

  always_comb begin
    rise     = db_next & ~db;
    fall     = ~db_next & db;
    pop_rise = popcount(rise);
    pop_fall = popcount(fall);
    wr       = valid & (|wstrb);
    w1c      = (wr && address == A_CHANGED) ? wdata[N_SENSORS-1:0] : '0;
  end

  always_comb begin
    rd_val = '0;
    case (address)
      A_STATUS:   rd_val[N_SENSORS-1:0] = db;
      A_OCCUPIED: rd_val[PC_W-1:0]      = popcount(db);
      A_CHANGED:  rd_val[N_SENSORS-1:0] = changed;
      A_MASK:     rd_val[N_SENSORS-1:0] = mask;
      A_DEBOUNCE: rd_val[CNT_W-1:0]     = dbnc;
      A_ENTRIES:  rd_val                = entries;
      A_EXITS:    rd_val                = exits;
      default:    rd_val                = '0;
    endcase
  end

  // Bus handshake: a request is a single-cycle valid; ready pulses for exactly one
  // cycle on the following cycle, with rdata holding the value sampled at the
  // valid edge (0 for writes and whenever ready is low). Requests may be back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      s         <= '0;
      db        <= '0;
      changed   <= '0;
      mask      <= '0;
      entries   <= '0;
      exits     <= '0;
      dbnc      <= CNT_W'(DEBOUNCE_RST);
      ready     <= 1'b0;
      rdata     <= '0;
      for (int i = 0; i < N_SENSORS; i++) cnt[i] <= '0;
    end else begin
      sync1   <= sensor_in;
      s       <= sync1;
      db      <= db_next;
      for (int i = 0; i < N_SENSORS; i++) cnt[i] <= cnt_next[i];
      // Edges are OR-ed in after the clear so a simultaneous set wins.
      changed <= (changed & ~w1c) | rise | fall;
      if (wr && address == A_MASK)     mask <= wdata[N_SENSORS-1:0];
      if (wr && address == A_DEBOUNCE) dbnc <= wdata[CNT_W-1:0];
      entries <= (wr && address == A_ENTRIES) ? DATA_W'(pop_rise) : sat_add(entries, pop_rise);
      exits   <= (wr && address == A_EXITS)   ? DATA_W'(pop_fall) : sat_add(exits, pop_fall);
      ready   <= valid;
      rdata   <= (valid && !wr) ? rd_val : '0;
    end
  end

  assign sensor_db = db;
  assign irq       = |(changed & mask);

endmodule
